// File: rtl/pst_sched_ctrl_pkg.sv
// Shared types and constants for the PST stimulus scheduler.
package pst_sched_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_SYNC = 2'd1,
        ST_RUN       = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    localparam int CUR_W = 8;
    localparam int LEN_W = 8;
    localparam int IDX_W = 2;
    localparam int CNT_W = 8;

    localparam logic [CNT_W-1:0] CONV_TIMEOUT = 8'hFF;

    // A zero-length entry still occupies one gamma cycle.
    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
        return (len == '0) ? LEN_W'(1) : len;
    endfunction

endpackage

// File: rtl/pst_sched_ctrl_conv_detect.sv
// Convergence detector: counts consecutive in-tolerance error samples per entry.
module pst_conv_detect
    import pst_sched_ctrl_pkg::*;
#(
    parameter int CONV_RUN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       sample_valid,
    input  logic [7:0] error_l2,
    input  logic [7:0] err_tol,
    output logic       hit,
    output logic       converged
);

    localparam int RCW = $clog2(CONV_RUN + 1);
    localparam logic [RCW-1:0] RUN_MAX  = RCW'(CONV_RUN);
    localparam logic [RCW-1:0] RUN_LAST = RCW'(CONV_RUN - 1);

    logic [RCW-1:0] run_cnt;
    logic           in_tol;

    assign in_tol = (error_l2 <= err_tol);
    // hit is combinational so the caller can report it on the same clock as an entry end
    assign hit    = sample_valid && in_tol && !converged && (run_cnt == RUN_LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            run_cnt   <= '0;
            converged <= 1'b0;
        end else if (sample_valid) begin
            if (!in_tol)
                run_cnt <= '0;
            else if (run_cnt != RUN_MAX)
                run_cnt <= run_cnt + RCW'(1);
            if (hit)
                converged <= 1'b1;
        end
    end

endmodule

// File: rtl/pst_sched_ctrl.sv
// Schedules a table of input currents into a 2-layer PST, one entry per span of
// gamma cycles, and reports per-entry convergence of the prediction error.
//
//   state        | meaning
//   ST_IDLE      | waiting for start, outputs quiet, table writable
//   ST_WAIT_SYNC | start seen, waiting for a gamma boundary
//   ST_RUN       | driving an entry, learning enabled
//   ST_DONE      | one-clk completion pulse, table writable
module pst_sched_ctrl
    import pst_sched_ctrl_pkg::*;
#(
    parameter int NPHASE   = 4,
    parameter int CONV_RUN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cycle_start,
    input  logic             start,
    input  logic             abort,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [CUR_W-1:0] cfg_cur,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [2:0]       num_phases,
    input  logic [7:0]       err_tol,
    input  logic [7:0]       error_l2,
    input  logic             error_valid,
    output logic [CUR_W-1:0] cur_out,
    output logic             learn_en,
    output logic [IDX_W-1:0] phase_idx,
    output logic             busy,
    output logic             conv_valid,
    output logic [CNT_W-1:0] conv_cycles,
    output logic             done
);

    state_t           state;
    logic [CUR_W-1:0] cur_tab [NPHASE];
    logic [LEN_W-1:0] len_tab [NPHASE];
    logic [CNT_W-1:0] cycle_cnt;
    logic [IDX_W-1:0] next_idx;
    logic [2:0]       eff_np;
    logic             last_entry;
    logic             entry_end;
    logic             conv_hit;
    logic             converged;
    logic             det_clear;

    assign busy       = (state == ST_WAIT_SYNC) || (state == ST_RUN);
    assign next_idx   = phase_idx + IDX_W'(1);
    assign eff_np     = (num_phases == 3'd0)         ? 3'd1 :
                        (num_phases > 3'(NPHASE))    ? 3'(NPHASE) : num_phases;
    assign last_entry = ({1'b0, phase_idx} == (eff_np - 3'd1));
    assign entry_end  = (state == ST_RUN) && cycle_start &&
                        (({1'b0, cycle_cnt} + 9'd1) >= {1'b0, eff_len(len_tab[phase_idx])});
    assign det_clear  = (state != ST_RUN) || entry_end;

    pst_conv_detect #(.CONV_RUN(CONV_RUN)) u_conv_detect (
        .clk          (clk),
        .rst          (rst),
        .clear        (det_clear),
        .sample_valid (error_valid && (state == ST_RUN)),
        .error_l2     (error_l2),
        .err_tol      (err_tol),
        .hit          (conv_hit),
        .converged    (converged)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NPHASE; i++) begin
                cur_tab[i] <= '0;
                len_tab[i] <= LEN_W'(1);
            end
        end else if (cfg_we && !busy) begin
            cur_tab[cfg_addr] <= cfg_cur;
            len_tab[cfg_addr] <= cfg_len;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cur_out     <= '0;
            learn_en    <= 1'b0;
            phase_idx   <= '0;
            conv_valid  <= 1'b0;
            conv_cycles <= '0;
            done        <= 1'b0;
            cycle_cnt   <= '0;
        end else begin
            conv_valid <= 1'b0;
            done       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start)
                        state <= ST_WAIT_SYNC;
                end
                ST_WAIT_SYNC: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (cycle_start) begin
                        state     <= ST_RUN;
                        phase_idx <= '0;
                        cur_out   <= cur_tab[0];
                        learn_en  <= 1'b1;
                        cycle_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state     <= ST_IDLE;
                        cur_out   <= '0;
                        learn_en  <= 1'b0;
                        phase_idx <= '0;
                        cycle_cnt <= '0;
                    end else begin
                        // a real convergence wins over a timeout on the same clock
                        if (conv_hit) begin
                            conv_valid  <= 1'b1;
                            conv_cycles <= cycle_cnt;
                        end else if (entry_end && !converged) begin
                            conv_valid  <= 1'b1;
                            conv_cycles <= CONV_TIMEOUT;
                        end
                        if (entry_end) begin
                            cycle_cnt <= '0;
                            if (last_entry) begin
                                state    <= ST_DONE;
                                cur_out  <= '0;
                                learn_en <= 1'b0;
                            end else begin
                                phase_idx <= next_idx;
                                cur_out   <= cur_tab[next_idx];
                            end
                        end else if (cycle_start && (cycle_cnt != CONV_TIMEOUT)) begin
                            cycle_cnt <= cycle_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    done      <= 1'b1;
                    phase_idx <= '0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/pst_sched_ctrl.md
PST_SCHED_CTRL -- requirements
Module: pst_sched_ctrl

Interface
REQ-001 Parameter NPHASE, 4, number of stimulus-table entries (index width 2).
REQ-002 Parameter CONV_RUN, 4, consecutive in-tolerance error samples that declare convergence.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 cycle_start  in  1  one-clk pulse from gamma oscillator marking gamma-cycle boundary.
REQ-006 start  in  1  begin schedule; sampled only in IDLE.
REQ-007 abort  in  1  terminate schedule; return to IDLE.
REQ-008 cfg_we  in  1  table write strobe.
REQ-009 cfg_addr  in  2  table entry index.
REQ-010 cfg_cur  in  8  input current for entry.
REQ-011 cfg_len  in  8  entry duration in gamma cycles.
REQ-012 num_phases  in  3  active entries, 1..4.
REQ-013 err_tol  in  8  convergence tolerance on L2 error magnitude.
REQ-014 error_l2  in  8  L2 prediction-error magnitude.
REQ-015 error_valid  in  1  error_l2 qualifier, one clk per sample.
REQ-016 cur_out  out  8  current driven into the 2-layer PST input.
REQ-017 learn_en  out  1  learning enable to the PST layers.
REQ-018 phase_idx  out  2  active table entry.
REQ-019 busy  out  1  high in WAIT_SYNC and RUN.
REQ-020 conv_valid  out  1  one-clk result pulse per entry.
REQ-021 conv_cycles  out  8  gamma cycles to convergence; 8'hFF = timeout.
REQ-022 done  out  1  one-clk pulse at schedule completion.

Function
REQ-023 States IDLE, WAIT_SYNC, RUN, DONE; one-hot or binary at implementer's choice.
REQ-024 IDLE: start=1 -> WAIT_SYNC next clk; cur_out=0, learn_en=0.
REQ-025 WAIT_SYNC: on cycle_start -> RUN, phase_idx=0, cur_out=table[0].cur, cycle counter=0, run counter=0; entry changes align to gamma boundaries only.
REQ-026 RUN: learn_en=1; each cycle_start increments cycle counter, saturating at 255.
REQ-027 RUN: error_valid with error_l2<=err_tol increments run counter (saturating at CONV_RUN); error_valid with error_l2>err_tol clears it.
REQ-028 First clk run counter reaches CONV_RUN within an entry: conv_valid=1 one clk, conv_cycles=cycle counter, entry marked converged; no further conv_valid for that entry.
REQ-029 Entry end: cycle_start with cycle counter+1 >= effective len; cfg_len=0 treated as 1.
REQ-030 Entry end, not converged: conv_valid=1 one clk, conv_cycles=8'hFF.
REQ-031 Entry end, not last: phase_idx+1, cur_out=next cur on same clk, counters and converged flag cleared.
REQ-032 Entry end, last (phase_idx = effective num_phases-1): -> DONE; num_phases 0 treated as 1, values >4 treated as 4.
REQ-033 DONE: done=1 one clk, cur_out=0, learn_en=0, -> IDLE next clk.
REQ-034 Same-clk convergence and entry end: convergence reported (real count), not timeout; exactly one conv_valid.
REQ-035 error_valid coincident with cycle_start: sample attributed to outgoing entry.
REQ-036 abort in WAIT_SYNC/RUN: IDLE next clk, no conv_valid, no done; abort outranks all events.
REQ-037 cfg_we ignored while busy=1; writes in IDLE/DONE take effect next clk.
REQ-038 start while busy ignored.

Reset
REQ-039 rst: state=IDLE, cur_out=0, learn_en=0, phase_idx=0, busy=0, conv_valid=0, conv_cycles=0, done=0, counters 0.
REQ-040 rst clears table to cur=0, len=1; rst mid-RUN overrides abort and all events.

Structure
REQ-041 Shared package holds state encoding, CONV_TIMEOUT=8'hFF, table entry width constants.
REQ-042 One sub-module, pst_conv_detect (run counter, tolerance compare, converged flag), instantiated once.

Verification
REQ-043 Table {50,32},{100,32}, tol=2, error_l2 falls to 1 at cycle 6 of entry 0 -> conv_valid, conv_cycles=9 (6 + 3 further samples), phase_idx=1 at cycle 32, cur_out=100.
REQ-044 Error never <=tol, len=8, one entry -> conv_valid conv_cycles=8'hFF at 8th cycle_start, done next clk.
REQ-045 4th in-tolerance sample on same clk as entry-end cycle_start -> single conv_valid with real count, no FF.
REQ-046 abort at cycle 5 of entry 1 -> IDLE next clk, cur_out=0, learn_en=0, no done.
REQ-047 cfg_we with cfg_cur=77 during RUN -> table unchanged; rerun shows original cur_out.
REQ-048 num_phases=0, cfg_len=0 -> one entry of 1 gamma cycle, timeout conv_valid, done.
